// File: rtl/imem_loader.sv
// Instruction-memory loader: streams words from a source into IMEM, then releases the CPU.
// Latency: one cycle from an acked input word to the IMEM write; one cycle from start to syn.
// Flow: the source is paced by syn/ack; a stalled source is cut off after TIMEOUT idle cycles.
module imem_loader #(
  parameter int IWIDTH  = 32,
  parameter int AWIDTH  = 8,
  parameter int MAXW    = 128,
  parameter int TIMEOUT = 16
) (
  input  logic              ld_clk,
  input  logic              ld_rst,
  input  logic              ld_i_start,
  input  logic [IWIDTH-1:0] ld_i_instr,
  input  logic              ld_i_ack,
  input  logic              ld_i_last,
  output logic              ld_o_syn,
  output logic              ld_o_we,
  output logic [AWIDTH-1:0] ld_o_addr,
  output logic [IWIDTH-1:0] ld_o_data,
  output logic [AWIDTH:0]   ld_o_count,
  output logic              ld_o_run,
  output logic              ld_o_done,
  output logic              ld_o_err
);

  // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tmo, tmo_nxt;
  logic              syn_nxt, we_nxt, run_nxt, done_nxt, err_nxt;
  logic [AWIDTH-1:0] addr_nxt;
  logic [IWIDTH-1:0] data_nxt;
  logic [AWIDTH:0]   count_nxt;

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo;
    syn_nxt   = ld_o_syn;
    we_nxt    = 1'b0;
    addr_nxt  = ld_o_addr;
    data_nxt  = ld_o_data;
    count_nxt = ld_o_count;
    run_nxt   = ld_o_run;
    done_nxt  = ld_o_done;
    err_nxt   = ld_o_err;
    case (state)
      LOAD: begin
        // start is deliberately ignored while a load is in flight
        if (ld_i_ack) begin
          we_nxt    = 1'b1;
          addr_nxt  = ld_o_count[AWIDTH-1:0];
          data_nxt  = ld_i_instr;
          count_nxt = ld_o_count + (AWIDTH+1)'(1);
          tmo_nxt   = '0;
          if (ld_i_last) begin
            state_nxt = DONE;
            syn_nxt   = 1'b0;
            done_nxt  = 1'b1;
            run_nxt   = 1'b1;
          end else if (ld_o_count == (AWIDTH+1)'(MAXW-1)) begin
            // memory full and the source still has more: overflow
            state_nxt = ERR;
            syn_nxt   = 1'b0;
            err_nxt   = 1'b1;
          end
        end else if (tmo == TW'(TIMEOUT-1)) begin
          state_nxt = ERR;
          syn_nxt   = 1'b0;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo + TW'(1);
        end
      end
      default: begin
        // IDLE, DONE, ERR: status holds until a new start; stray ack/last are ignored
        if (ld_i_start) begin
          state_nxt = LOAD;
          syn_nxt   = 1'b1;
          count_nxt = '0;
          run_nxt   = 1'b0;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
          tmo_nxt   = '0;
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ld_clk) begin
    if (!ld_rst) begin
      state      <= IDLE;
      tmo        <= '0;
      ld_o_syn   <= 1'b0;
      ld_o_we    <= 1'b0;
      ld_o_addr  <= '0;
      ld_o_data  <= '0;
      ld_o_count <= '0;
      ld_o_run   <= 1'b0;
      ld_o_done  <= 1'b0;
      ld_o_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmo        <= tmo_nxt;
      ld_o_syn   <= syn_nxt;
      ld_o_we    <= we_nxt;
      ld_o_addr  <= addr_nxt;
      ld_o_data  <= data_nxt;
      ld_o_count <= count_nxt;
      ld_o_run   <= run_nxt;
      ld_o_done  <= done_nxt;
      ld_o_err   <= err_nxt;
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameters SHALL be, one per line:
- IWIDTH, 32, instruction word width
- AWIDTH, 8, instruction-memory word-address width
- MAXW, 128, maximum words per load, MAXW <= 2^AWIDTH
- TIMEOUT, 16, maximum cycles to wait for an ack
REQ-002 Ports SHALL be, one per line:
- ld_clk, in, 1, single clock, all logic on rising edge
- ld_rst, in, 1, synchronous active-low reset
- ld_i_start, in, 1, single-cycle request to begin a load
- ld_i_instr, in, IWIDTH, word from the instruction source
- ld_i_ack, in, 1, ld_i_instr valid this cycle
- ld_i_last, in, 1, current acked word is the final word
- ld_o_syn, out, 1, request to the source to stream words
- ld_o_we, out, 1, instruction-memory write enable
- ld_o_addr, out, AWIDTH, write word address
- ld_o_data, out, IWIDTH, write data
- ld_o_count, out, AWIDTH+1, words written in the current or last load
- ld_o_run, out, 1, CPU release; 0 holds the CPU in reset
- ld_o_done, out, 1, load completed successfully
- ld_o_err, out, 1, load failed (timeout or overflow)
REQ-003 The design SHALL use one clock; reset SHALL be synchronous and active-low on ld_rst, sampled only at the ld_clk rising edge.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 FSM states SHALL be IDLE, LOAD, DONE and ERR.
REQ-006 In IDLE, DONE or ERR, ld_i_start=1 SHALL move the FSM to LOAD at the next edge and, at that same edge, set syn=1, count=0, run=0, done=0, err=0 and the timeout counter to 0.
REQ-007 In LOAD, ld_i_start SHALL be ignored.
REQ-008 In LOAD, an ack cycle SHALL produce, at the next edge: we=1, addr=count[AWIDTH-1:0], data=ld_i_instr, count=count+1, timeout counter=0.
REQ-009 ld_o_we SHALL be 1 for exactly one cycle per accepted ack and 0 at all other times.
REQ-010 ack=1 and last=1 in LOAD SHALL write that word and, at the same edge, set state=DONE, syn=0, done=1 and run=1.
REQ-011 ack=1, last=0 and count==MAXW-1 in LOAD SHALL write that word and, at the same edge, set state=ERR, syn=0 and err=1 (overflow).
REQ-012 A LOAD cycle with ack=0 SHALL increment the timeout counter.
REQ-013 When the timeout counter reaches TIMEOUT-1 with ack=0, the next edge SHALL set state=ERR, syn=0 and err=1, with no write.
REQ-014 ack or last received outside LOAD SHALL be ignored: no write, no count change. This covers the extra source beat after syn drops.
REQ-015 last=1 with ack=0 SHALL be ignored.
REQ-016 ld_o_done, ld_o_err and ld_o_run SHALL hold their values in DONE and ERR until the next start or reset.
REQ-017 run SHALL be 1 only in DONE; in ERR, run SHALL stay 0.
REQ-018 ld_o_count SHALL hold the final word count in DONE and ERR.
REQ-019 The latency from an acked word on the inputs to the ld_o_we pulse SHALL be one cycle.
REQ-020 The latency from start to syn=1 SHALL be one cycle.

Reset
REQ-021 ld_rst=0 at an edge SHALL force state=IDLE, syn=0, we=0, addr=0, data=0, count=0, run=0, done=0, err=0 and the timeout counter to 0, overriding all other inputs.
REQ-022 A reset asserted during LOAD SHALL abort the load with no further writes; after release, the block SHALL stay in IDLE until a start.

Verification
REQ-023 Reset, then hold ld_rst=1 for 5 idle cycles -> all outputs 0, syn stays 0.
REQ-024 Start; source acks 7 words 0x20080005.. consecutively with last on the 7th -> 7 we pulses, addr 0..6 with matching data, count=7, syn=0, done=1, run=1; an ack on the cycle after last produces no write.
REQ-025 Start; 4 words acked every third cycle, last on the 4th -> no timeout, 4 writes at addr 0..3, done=1.
REQ-026 Start; no ack for 16 cycles -> err=1, syn=0, run=0, count=0, no writes; a second start then a 2-word load -> done=1, err=0, count=2.
REQ-027 With MAXW=8, start; 10 acks, never last -> exactly 8 writes (addr 0..7), err=1, syn=0 on the edge of the 8th write.
REQ-028 Start, 3 acks, ld_rst=0 for one cycle, then 2 more acks -> writes stop after addr 2, all outputs 0, FSM in IDLE; a further start begins again at addr 0.
